// File: rtl/pq_sorted_datapath.sv
// Storage and compare datapath for the sorted-array priority queue.
// Keys are held ascending in a flop array; all-ones marks an empty slot.
module pq_sorted_datapath #(
    parameter int KEY_W  = 16,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [KEY_W-1:0] din,
    input  logic             regenb,
    input  logic             regsel,
    input  logic             we,
    input  logic             countenb,
    input  logic             deq_shift,
    output logic             result,
    output logic             addr_last,
    output logic [KEY_W-1:0] head_key,
    output logic             full,
    output logic             empty
);

    localparam logic [KEY_W-1:0]  SENT = '1;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    logic [KEY_W-1:0]  mem [DEPTH];
    logic [KEY_W-1:0]  kreg;
    logic [ADDR_W-1:0] addr;
    logic [KEY_W-1:0]  rd_key;

    always_comb begin
        rd_key    = mem[addr];
        result    = (kreg > rd_key);
        addr_last = (addr == LAST);
        head_key  = mem[0];
        full      = (mem[DEPTH-1] != SENT);
        empty     = (mem[0] == SENT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= SENT;
            end
            kreg <= SENT;
            addr <= '0;
        end else if (deq_shift) begin
            // Dequeue pre-empts any walk strobes in the same cycle.
            if (!empty) begin
                for (int unsigned i = 0; i < DEPTH - 1; i++) begin
                    mem[i] <= mem[i+1];
                end
                mem[DEPTH-1] <= SENT;
            end
        end else begin
            // Reads use pre-edge values, so we + regsel=1 forms an atomic swap.
            if (we) begin
                mem[addr] <= kreg;
            end
            if (regenb && !regsel) begin
                kreg <= din;
                addr <= '0;
            end else begin
                if (regenb) begin
                    kreg <= rd_key;
                end
                if (countenb && (addr != LAST)) begin
                    addr <= addr + 1'b1;
                end
            end
        end
    end

endmodule
